// File: rtl/onehot_request_encoder.sv
// onehot_request_encoder
// Turns rising edges on four request lines into a registered 2-bit index
// stream with a valid/ready handshake. Each edge is held as a pending event
// until its index is accepted. Arbitration is round-robin or fixed priority.

module onehot_request_encoder #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [3:0] requestIn,
    input  logic       indexReady,
    output logic [1:0] indexOut,
    output logic       indexValid,
    output logic [3:0] pendingOut,
    output logic       overflowOut
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state;
    logic [3:0] reqPrev;
    logic [3:0] pending;
    logic [1:0] lastGrant;

    logic [3:0] rise;
    logic       accept;
    logic [3:0] acceptMask;
    logic [3:0] selSrc;
    logic [1:0] selIdx;
    logic [1:0] probe;

    // Edge detect, handshake and the selection source (accepted bit masked out)
    always_comb begin
        rise       = requestIn & ~reqPrev;
        accept     = indexValid && indexReady;
        acceptMask = accept ? (4'b0001 << indexOut) : 4'b0000;
        selSrc     = pending & ~acceptMask;
    end

    // Arbiter: round-robin starts one past lastGrant and wraps; fixed picks the highest bit.
    // Loops walk from lowest to highest priority so the last hit wins.
    always_comb begin
        selIdx = 2'b00;
        probe  = 2'b00;
        if (RR_ENABLE) begin
            for (int i = 4; i >= 1; i--) begin
                probe = lastGrant + 2'(i);
                if (selSrc[probe]) selIdx = probe;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (selSrc[i]) selIdx = 2'(i);
            end
        end
    end

    // Event capture, pending bookkeeping, overflow pulse and last-grant tracking
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            reqPrev     <= 4'b0000;
            pending     <= 4'b0000;
            overflowOut <= 1'b0;
            lastGrant   <= 2'b11;
        end else begin
            reqPrev     <= requestIn;
            // A rise on the bit being accepted re-arms it as a fresh event
            pending     <= (pending & ~acceptMask) | rise;
            // Rise onto a bit still waiting merges with it; flag it for one cycle
            overflowOut <= |(rise & pending & ~acceptMask);
            if (accept) lastGrant <= indexOut;
        end
    end

    // Output FSM: present an index, hold it under backpressure, chain on accept
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            indexOut   <= 2'b00;
            indexValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending != 4'b0000) begin
                        indexOut   <= selIdx;
                        indexValid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        if (selSrc != 4'b0000) begin
                            indexOut <= selIdx;
                        end else begin
                            indexValid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    indexValid <= 1'b0;
                end
            endcase
        end
    end

    assign pendingOut = pending;

endmodule

// File: doc/onehot_request_encoder.md
# onehot_request_encoder

Converts four independent request lines into a registered 2-bit index stream with a valid/ready handshake. It is the inverse of the 2-to-4 decode used on the select path: the decoder turns an index into one-hot lines, and this block turns one-hot event lines back into indices. It sits between the SD-card readout event sources and the index consumer. Every rising edge on a request line is captured, held until served, and reported exactly once. Arbitration is round-robin or fixed priority.

## Interface
- RR_ENABLE, default 1: 1 = round-robin arbitration; 0 = fixed priority, highest bit wins.
- clock  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- requestIn  in  4  request lines, sampled every cycle; rising edges are events.
- indexReady  in  1  consumer accepts indexOut when high with indexValid.
- indexOut  out  2  binary index of the granted request (bit3 -> 2'b11 ... bit0 -> 2'b00).
- indexValid  out  1  indexOut holds a pending grant.
- pendingOut  out  4  captured, unserved events, including the one currently presented.
- overflowOut  out  1  one-cycle pulse when an event hits an already-pending bit.

## Operation
- Edge capture: reqPrev register, rise = requestIn & ~reqPrev. Level-held requests produce one event only.
- Pending register update at each edge: pending <= (pending & ~acceptMask) | rise.
  - acceptMask is the one-hot of indexOut when indexValid && indexReady.
  - A rise on the bit being accepted in the same cycle leaves that bit set, as a new event.
- Overflow: rise[i] && pending[i] && !acceptMask[i] -> overflowOut high for the next cycle. Pending is unchanged (events merge).
- Selection source: pending & ~acceptMask.
  - RR_ENABLE=1: search starts at lastGrant+1, wraps 3->0, first set bit wins.
  - RR_ENABLE=0: highest set bit wins.
- lastGrant (2 bits) is updated to indexOut on each accept.
- FSM:
  - IDLE: indexValid=0. If pending != 0, load indexOut from selection, set indexValid, go to HOLD.
  - HOLD: indexOut and indexValid stay stable while indexReady=0.
    - On accept with a nonzero selection source: load the next index, stay in HOLD, keep valid high.
    - On accept with an empty selection source: drop valid, go to IDLE.
- Events captured at the accept edge are not in the selection source at that edge; they are considered on the following edge.

## Timing
- Reset (resetN low, asynchronous): indexOut=2'b00, indexValid=0, pendingOut=4'b0000, overflowOut=0, reqPrev=0, lastGrant=2'b11, FSM=IDLE.
  - Any state mid-operation is discarded.
  - A request held high across reset release counts as a rise on the first edge.
- Latency: a rise sampled at edge k sets pending after k. indexValid goes high after edge k+1 (2 cycles from IDLE).
- Throughput: with indexReady held high and multiple bits pending, one index is accepted per cycle with no valid gaps.
- Handshake: the transfer happens on an edge where indexValid && indexReady. indexReady while indexValid=0 has no effect.
- overflowOut is never high for more than one cycle per overflow edge. Back-to-back overflows give back-to-back pulses.
- pendingOut is registered and updates on the same edges as the pending register.

## Test plan
- Single event: requestIn 0000->0010 at edge k, indexReady=1 -> indexValid=1 and indexOut=01 after k+1. indexValid=0 and pendingOut=0000 after k+2.
- Round-robin burst: RR_ENABLE=1, requestIn 0000->1111 after reset, indexReady=1 -> indexOut 00,01,10,11 on four consecutive cycles with indexValid continuously high, then indexValid=0.
- Fixed priority: RR_ENABLE=0, same stimulus -> indexOut 11,10,01,00.
- Backpressure and overflow:
  - requestIn bit2 pulses, indexReady=0 for 5 cycles -> indexOut=10 stable, indexValid=1.
  - A second bit2 pulse -> overflowOut high for exactly 1 cycle, pendingOut=0100.
  - Release indexReady -> a single accept.
- Level hold: requestIn=0001 held 10 cycles, indexReady=1 -> exactly one transfer with indexOut=00. No overflow.
- Reset mid-HOLD: indexValid=1, then resetN low asynchronously -> all outputs at reset values before the next clock edge. requestIn=1000 held across release -> one transfer with indexOut=11.
